// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: APB register offsets, STATUS bit
// positions and the receiver FSM encoding.
package uart_pkg;

    localparam logic [3:0] RXDATA_OFS = 4'h0;
    localparam logic [3:0] STATUS_OFS = 4'h4;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME_ERR = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push on full succeeds only when a
// pop happens in the same cycle, pop on empty is ignored.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_DIFF = {1'b1, {AW{1'b0}}};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = ((wr_ptr_q ^ rd_ptr_q) == FULL_DIFF);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign dout     = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: empty pointers hide stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_apb.sv
// APB-slave 8N1 UART receiver with receive FIFO and sticky error bits.
// Optional registered interrupt enabled by defining UART_RX_IRQ_EN.
module uart_rx_apb #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    input  logic        rx,
    output logic        irq
);
    import uart_pkg::*;

    // state   | meaning
    // IDLE    | waiting for falling edge on synchronised rx
    // START   | half-bit wait, confirm start bit still low
    // DATA    | sample 8 data bits LSB first, one per bit period
    // STOP    | sample stop bit, push byte or flag frame error
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e       state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            overrun_q, overrun_d;
    logic            frame_err_q, frame_err_d;

    logic            stop_tick, push, ferr_set, ovr_set;
    logic            access, rd_rxdata, wr_status, pop;
    logic [1:0]      reg_sel;
    logic [7:0]      fifo_dout;
    logic            fifo_full, fifo_empty;
    logic [31:0]     status_w;
    logic            unused_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s2_q && rx_prev_q) begin
                        state_q   <= S_START;
                        cnt_q     <= CNT_HALF;
                        bit_cnt_q <= '0;
                    end
                end
                S_START: begin
                    if (cnt_q == '0) begin
                        if (!rx_s2_q) begin
                            state_q <= S_DATA;
                            cnt_q   <= CNT_FULL;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rx_s2_q, shift_q[7:1]};
                        cnt_q   <= CNT_FULL;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Push is decoded straight from the stop sample so the byte lands one
    // edge after the synchroniser delivers the stop bit.
    assign stop_tick = (state_q == S_STOP) && (cnt_q == '0);
    assign push      = stop_tick & rx_s2_q;
    assign ferr_set  = stop_tick & ~rx_s2_q;

    assign access    = psel & penable;
    assign reg_sel   = paddr[3:2];
    assign rd_rxdata = access & ~pwrite & (reg_sel == RXDATA_OFS[3:2]);
    assign wr_status = access &  pwrite & (reg_sel == STATUS_OFS[3:2]);
    assign pop       = rd_rxdata;
    assign ovr_set   = push & fifo_full & ~pop;

    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (shift_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Set events take priority over a same-cycle W1C.
    assign overrun_d   = ovr_set  | (overrun_q   & ~(wr_status & pwdata[STAT_OVERRUN]));
    assign frame_err_d = ferr_set | (frame_err_q & ~(wr_status & pwdata[STAT_FRAME_ERR]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        status_w                 = '0;
        status_w[STAT_NOT_EMPTY] = ~fifo_empty;
        status_w[STAT_FULL]      = fifo_full;
        status_w[STAT_OVERRUN]   = overrun_q;
        status_w[STAT_FRAME_ERR] = frame_err_q;
    end

    always_comb begin
        prdata = '0;
        if (access && !pwrite) begin
            if (reg_sel == RXDATA_OFS[3:2]) begin
                prdata = fifo_empty ? 32'h0 : {24'h0, fifo_dout};
            end else if (reg_sel == STATUS_OFS[3:2]) begin
                prdata = status_w;
            end
        end
    end

    assign pready      = 1'b1;
    assign unused_bits = ^{paddr[31:4], paddr[1:0], pwdata[31:4], pwdata[1:0]};

`ifdef UART_RX_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= ~fifo_empty | overrun_q | frame_err_q;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_apb.sv
// Self-checking bench for uart_rx_apb: serial frames are driven on rx, expected
// bytes and sticky flags are modelled in a scoreboard queue and checked over APB.
module tb_uart_rx_apb;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [31:0] paddr = '0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        rx = 1'b1;
    logic        irq;

    int   checks = 0;
    int   failures = 0;
    logic [7:0] sb[$];
    logic exp_ovr = 1'b0;
    logic exp_ferr = 1'b0;

    uart_rx_apb #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .psel    (psel),
        .penable (penable),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .rx      (rx),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_status();
        return {28'h0, exp_ferr, exp_ovr, sb.size() == DEPTH, sb.size() != 0};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1 d = prdata;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] v);
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = v; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Model update happens up front; the frame then takes 160 cycles on the pin.
    task automatic send_byte(input logic [7:0] d, input logic stop);
        if (stop) begin
            if (sb.size() < DEPTH) sb.push_back(d);
            else exp_ovr = 1'b1;
        end else begin
            exp_ferr = 1'b1;
        end
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        idle(3);
        checks++;
        if (prdata !== 32'h0 || pready !== 1'b1 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got prdata=%h pready=%b irq=%b exp 0/1/0", prdata, pready, irq);
        end
        rst_n = 1'b1;
        idle(2);
        apb_read(32'hFFFF_0004, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=%h", d, 32'h0); end
        apb_read(32'hFFFF_0000, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_rxdata_empty got=%h exp=%h", d, 32'h0); end
        apb_write(32'hFFFF_0008, 32'hFFFF_FFFF);
        apb_read(32'hFFFF_0008, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reg2_read got=%h exp=%h", d, 32'h0); end
    endtask

    task automatic test_single();
        logic [31:0] d;
        logic [7:0]  e;
        send_byte(8'hA5, 1'b1);
        idle(2);
        apb_read(32'hFFFF_0004, d);
        checks++;
        if (d !== exp_status()) begin failures++; $display("FAIL single_status got=%h exp=%h", d, exp_status()); end
`ifdef UART_RX_IRQ_EN
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL single_irq got=%b exp=1", irq); end
`else
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL single_irq_tied got=%b exp=0", irq); end
`endif
        e = sb.pop_front();
        apb_read(32'hFFFF_0000, d);
        checks++;
        if (d !== {24'h0, e}) begin failures++; $display("FAIL single_rxdata got=%h exp=%h", d, {24'h0, e}); end
        apb_read(32'hFFFF_0004, d);
        checks++;
        if (d !== exp_status()) begin failures++; $display("FAIL single_status_after got=%h exp=%h", d, exp_status()); end
    endtask

    task automatic test_burst_overrun();
        logic [31:0] d;
        logic [7:0]  e;
        for (int i = 0; i < 9; i++) send_byte(8'(i), 1'b1);
        idle(2);
        apb_read(32'hFFFF_0004, d);
        checks++;
        if (d !== exp_status()) begin failures++; $display("FAIL burst_status got=%h exp=%h", d, exp_status()); end
        while (sb.size() != 0) begin
            e = sb.pop_front();
            apb_read(32'hFFFF_0000, d);
            checks++;
            if (d !== {24'h0, e}) begin failures++; $display("FAIL burst_rxdata got=%h exp=%h", d, {24'h0, e}); end
        end
        apb_read(32'hFFFF_0000, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL burst_lost_byte got=%h exp=%h", d, 32'h0); end
        apb_read(32'hFFFF_0004, d);
        checks++;
        if (d !== exp_status()) begin failures++; $display("FAIL burst_sticky got=%h exp=%h", d, exp_status()); end
        apb_write(32'hFFFF_0004, 32'h4);
        exp_ovr = 1'b0;
        apb_read(32'hFFFF_0004, d);
        checks++;
        if (d !== exp_status()) begin failures++; $display("FAIL burst_w1c got=%h exp=%h", d, exp_status()); end
    endtask

    task automatic test_frame_err();
        logic [31:0] d;
        send_byte(8'h3C, 1'b0);
        idle(2);
        apb_read(32'hFFFF_0004, d);
        checks++;
        if (d !== exp_status()) begin failures++; $display("FAIL ferr_status got=%h exp=%h", d, exp_status()); end
        apb_read(32'hFFFF_0000, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL ferr_rxdata got=%h exp=%h", d, 32'h0); end
        apb_write(32'hFFFF_0004, 32'h8);
        exp_ferr = 1'b0;
        apb_read(32'hFFFF_0004, d);
        checks++;
        if (d !== exp_status()) begin failures++; $display("FAIL ferr_w1c got=%h exp=%h", d, exp_status()); end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        logic [7:0]  e;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(30);
        apb_read(32'hFFFF_0004, d);
        checks++;
        if (d !== exp_status()) begin failures++; $display("FAIL glitch_status got=%h exp=%h", d, exp_status()); end
        send_byte(8'h81, 1'b1);
        idle(2);
        e = sb.pop_front();
        apb_read(32'hFFFF_0000, d);
        checks++;
        if (d !== {24'h0, e}) begin failures++; $display("FAIL glitch_next_byte got=%h exp=%h", d, {24'h0, e}); end
    endtask

    task automatic test_full_pop_collision();
        logic [31:0] d;
        logic [7:0]  e;
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1);
        idle(2);
        apb_read(32'hFFFF_0004, d);
        checks++;
        if (d !== exp_status()) begin failures++; $display("FAIL coll_full got=%h exp=%h", d, exp_status()); end
        // Stop midpoint is 152 cycles after the start edge; push lands 3 later.
        e = sb.pop_front();
        fork
            send_byte(8'h18, 1'b1);
            begin
                idle(153);
                apb_read(32'hFFFF_0000, d);
            end
        join
        checks++;
        if (d !== {24'h0, e}) begin failures++; $display("FAIL coll_pop_data got=%h exp=%h", d, {24'h0, e}); end
        apb_read(32'hFFFF_0004, d);
        checks++;
        if (d !== exp_status()) begin failures++; $display("FAIL coll_status got=%h exp=%h", d, exp_status()); end
        while (sb.size() != 0) begin
            e = sb.pop_front();
            apb_read(32'hFFFF_0000, d);
            checks++;
            if (d !== {24'h0, e}) begin failures++; $display("FAIL coll_drain got=%h exp=%h", d, {24'h0, e}); end
        end
    endtask

    task automatic test_w1c_set_wins();
        logic [31:0] d;
        fork
            send_byte(8'h3C, 1'b0);
            begin
                idle(153);
                apb_write(32'hFFFF_0004, 32'h8);
            end
        join
        idle(2);
        apb_read(32'hFFFF_0004, d);
        checks++;
        if (d !== exp_status()) begin failures++; $display("FAIL setwins_status got=%h exp=%h", d, exp_status()); end
        apb_write(32'hFFFF_0004, 32'h8);
        exp_ferr = 1'b0;
        apb_read(32'hFFFF_0004, d);
        checks++;
        if (d !== exp_status()) begin failures++; $display("FAIL setwins_clear got=%h exp=%h", d, exp_status()); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        logic [7:0]  e;
        logic [7:0]  pat;
        send_byte(8'h11, 1'b1);
        pat = 8'hC3;
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = pat[i];
            idle(CPB);
        end
        rx = pat[4];
        idle(CPB / 2);
        rst_n = 1'b0;
        sb.delete();
        exp_ovr = 1'b0;
        exp_ferr = 1'b0;
        idle(3);
        rx = 1'b1;
        rst_n = 1'b1;
        idle(4);
        apb_read(32'hFFFF_0004, d);
        checks++;
        if (d !== exp_status()) begin failures++; $display("FAIL rstmid_status got=%h exp=%h", d, exp_status()); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rstmid_irq got=%b exp=0", irq); end
        send_byte(8'h5A, 1'b1);
        idle(2);
        apb_read(32'hFFFF_0004, d);
        checks++;
        if (d !== exp_status()) begin failures++; $display("FAIL rstmid_after_status got=%h exp=%h", d, exp_status()); end
`ifdef UART_RX_IRQ_EN
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL rstmid_irq_set got=%b exp=1", irq); end
`endif
        e = sb.pop_front();
        apb_read(32'hFFFF_0000, d);
        checks++;
        if (d !== {24'h0, e}) begin failures++; $display("FAIL rstmid_rxdata got=%h exp=%h", d, {24'h0, e}); end
        apb_read(32'hFFFF_0004, d);
        checks++;
        if (d !== exp_status()) begin failures++; $display("FAIL rstmid_final got=%h exp=%h", d, exp_status()); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_burst_overrun();
        test_frame_err();
        test_glitch();
        test_full_pop_collision();
        test_w1c_set_wins();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
